// File: rtl/monitoreo_pkg.sv
// Shared types and the sample classifier for the multi-channel temperature monitor.
package monitoreo_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        FRIO   = 2'b01,
        CALOR  = 2'b10
    } estado_e;

    typedef enum logic [1:0] {
        OK_C,
        FRIO_C,
        CALOR_C
    } clase_e;

    function automatic clase_e clasificar(
        input int muestra,
        input int lim_bajo,
        input int lim_alto
    );
        if (muestra < lim_bajo) return FRIO_C;
        if (muestra > lim_alto) return CALOR_C;
        return OK_C;
    endfunction

endpackage

// File: rtl/monitoreo_multicanal_canal.sv
// One channel: sample capture, pending flag, persistence counter and FSM
// with hysteresis on exit, plus registered actuator/state outputs.
module canal_temp
    import monitoreo_pkg::*;
#(
    parameter int ANCHO    = 11,
    parameter int LIM_BAJO = 150,
    parameter int LIM_ALTO = 350,
    parameter int HIST     = 20,
    parameter int PERSIST  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [ANCHO-1:0] muestra,
    input  logic                    valida,
    output logic                    calefactor,
    output logic                    ventilador,
    output logic [1:0]              estado_out,
    output logic                    falla,
    output logic                    falla_sig
);

    localparam int CW = $clog2(PERSIST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(PERSIST);
    localparam logic signed [ANCHO:0] BAJO   = (ANCHO+1)'(LIM_BAJO);
    localparam logic signed [ANCHO:0] ALTO   = (ANCHO+1)'(LIM_ALTO);
    localparam logic signed [ANCHO:0] BAJO_H = (ANCHO+1)'(LIM_BAJO + HIST);
    localparam logic signed [ANCHO:0] ALTO_H = (ANCHO+1)'(LIM_ALTO - HIST);

    logic signed [ANCHO-1:0] temp_q, temp_d;
    logic                    pend_q, pend_d;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_n;
    clase_e                  ult_q, ult_d, clase;
    estado_e                 estado_q, estado_d;
    logic                    cal_q, cal_d, ven_q, ven_d;
    logic [1:0]              est_q, est_d;
    logic signed [ANCHO:0]   t_x;

    always_comb begin
        temp_d   = valida ? muestra : temp_q;
        pend_d   = valida;
        cnt_d    = cnt_q;
        cnt_n    = cnt_q;
        ult_d    = ult_q;
        estado_d = estado_q;
        clase    = OK_C;
        t_x      = {temp_q[ANCHO-1], temp_q};
        cal_d    = (estado_q == FRIO);
        ven_d    = (estado_q == CALOR);
        est_d    = estado_q;
        if (pend_q) begin
            clase = clasificar(int'(temp_q), LIM_BAJO, LIM_ALTO);
            if (clase == OK_C)
                cnt_n = '0;
            else if (clase == ult_q && cnt_q != '0)
                cnt_n = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            else
                cnt_n = CW'(1);
            if (clase != OK_C)
                ult_d = clase;
            cnt_d = cnt_n;
            unique case (estado_q)
                NORMAL: begin
                    if (cnt_n == CNT_MAX && clase == FRIO_C)
                        estado_d = FRIO;
                    else if (cnt_n == CNT_MAX && clase == CALOR_C)
                        estado_d = CALOR;
                end
                FRIO: begin
                    if (t_x >= BAJO_H && t_x <= ALTO)
                        estado_d = NORMAL;
                    else if (cnt_n == CNT_MAX && clase == CALOR_C)
                        estado_d = CALOR;
                end
                CALOR: begin
                    if (t_x >= BAJO && t_x <= ALTO_H)
                        estado_d = NORMAL;
                    else if (cnt_n == CNT_MAX && clase == FRIO_C)
                        estado_d = FRIO;
                end
                default: estado_d = NORMAL;
            endcase
            // every transition starts a fresh run
            if (estado_d != estado_q)
                cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            temp_q   <= '0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            ult_q    <= OK_C;
            estado_q <= NORMAL;
            cal_q    <= 1'b0;
            ven_q    <= 1'b0;
            est_q    <= 2'b00;
        end else begin
            temp_q   <= temp_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            ult_q    <= ult_d;
            estado_q <= estado_d;
            cal_q    <= cal_d;
            ven_q    <= ven_d;
            est_q    <= est_d;
        end
    end

    assign calefactor = cal_q;
    assign ventilador = ven_q;
    assign estado_out = est_q;
    assign falla      = (estado_q != NORMAL);
    assign falla_sig  = (estado_d != NORMAL);

endmodule

// File: rtl/monitoreo_multicanal.sv
// Multi-channel temperature monitor top: per-channel slicing plus global alert.
// Define MONITOREO_ALERTA_RETENIDA_EN for a sticky alert cleared by alerta_clr.
module monitoreo_multicanal
    import monitoreo_pkg::*;
#(
    parameter int N_CANALES = 4,
    parameter int ANCHO     = 11,
    parameter int LIM_BAJO  = 150,
    parameter int LIM_ALTO  = 350,
    parameter int HIST      = 20,
    parameter int PERSIST   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_CANALES*ANCHO-1:0]   temp_entrada,
    input  logic [N_CANALES-1:0]         temp_valida,
    input  logic                         alerta_clr,
    output logic [N_CANALES-1:0]         calefactor,
    output logic [N_CANALES-1:0]         ventilador,
    output logic [2*N_CANALES-1:0]       estado_actual,
    output logic                         alerta
);

    logic [N_CANALES-1:0] falla, falla_sig;
    logic                 alerta_q, alerta_d;

    for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
        canal_temp #(
            .ANCHO    (ANCHO),
            .LIM_BAJO (LIM_BAJO),
            .LIM_ALTO (LIM_ALTO),
            .HIST     (HIST),
            .PERSIST  (PERSIST)
        ) u_canal (
            .clk        (clk),
            .rst        (rst),
            .muestra    (temp_entrada[i*ANCHO +: ANCHO]),
            .valida     (temp_valida[i]),
            .calefactor (calefactor[i]),
            .ventilador (ventilador[i]),
            .estado_out (estado_actual[2*i +: 2]),
            .falla      (falla[i]),
            .falla_sig  (falla_sig[i])
        );
    end

`ifdef MONITOREO_ALERTA_RETENIDA_EN
    // a clear never wins against a channel that is or is becoming faulted
    always_comb begin
        alerta_d = (|falla) |
                   (alerta_q & ~(alerta_clr & ~(|falla_sig)));
    end
`else
    logic unused_clr;
    assign unused_clr = alerta_clr ^ (|falla_sig);

    always_comb begin
        alerta_d = |falla;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            alerta_q <= 1'b0;
        else
            alerta_q <= alerta_d;
    end

    assign alerta = alerta_q;

endmodule

// File: tb/tb_monitoreo_multicanal.sv
// Scoreboard bench for monitoreo_multicanal: directed vectors with hand-computed expectations.
module tb_monitoreo_multicanal;

    localparam int N = 4;
    localparam int W = 11;
`ifdef MONITOREO_ALERTA_RETENIDA_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] temp_entrada;
    logic [N-1:0]   temp_valida;
    logic           alerta_clr;
    logic [N-1:0]   calefactor;
    logic [N-1:0]   ventilador;
    logic [2*N-1:0] estado_actual;
    logic           alerta;

    monitoreo_multicanal dut (
        .clk           (clk),
        .rst           (rst),
        .temp_entrada  (temp_entrada),
        .temp_valida   (temp_valida),
        .alerta_clr    (alerta_clr),
        .calefactor    (calefactor),
        .ventilador    (ventilador),
        .estado_actual (estado_actual),
        .alerta        (alerta)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] cal;
        logic [3:0] ven;
        logic [7:0] est;
        logic       al;
        string      nom;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: compares the DUT outputs against every expectation due this cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            if (e.cyc != cyc ||
                {calefactor, ventilador, estado_actual, alerta} !==
                {e.cal, e.ven, e.est, e.al}) begin
                fails++;
                $display("FAIL %s cyc=%0d (due %0d): got cal=%b ven=%b est=%b al=%b, expected cal=%b ven=%b est=%b al=%b",
                         e.nom, cyc, e.cyc, calefactor, ventilador, estado_actual, alerta,
                         e.cal, e.ven, e.est, e.al);
            end
        end
    end

    task automatic expect_at(input int d, input logic [3:0] cal, input logic [3:0] ven,
                             input logic [7:0] est, input logic al, input string nom);
        q.push_back('{cyc + d, cal, ven, est, al, nom});
    endtask

    task automatic drive(input logic [3:0] v, input int t0, input int t1,
                         input int t2, input int t3);
        @(negedge clk);
        temp_valida = v;
        temp_entrada[0*W +: W] = W'(t0);
        temp_entrada[1*W +: W] = W'(t1);
        temp_entrada[2*W +: W] = W'(t2);
        temp_entrada[3*W +: W] = W'(t3);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            temp_valida = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        alerta_clr   = 1'b0;
        temp_valida  = 4'hF;
        for (int i = 0; i < N; i++) temp_entrada[i*W +: W] = W'(500);

        // reset held two edges with strobes active
        @(negedge clk);
        expect_at(1, 4'b0, 4'b0, 8'b0, 1'b0, "reset_hold");
        @(negedge clk);
        rst         = 1'b0;
        temp_valida = '0;
        expect_at(2, 4'b0, 4'b0, 8'b0, 1'b0, "reset_release");
        idle(3);

        // cold entry on channel 0 with gaps
        for (int k = 0; k < 4; k++) begin
            drive(4'b0001, 100, 0, 0, 0);
            if (k == 2) expect_at(3, 4'b0, 4'b0, 8'b0, 1'b0, "cold_third");
            if (k == 3) begin
                expect_at(2, 4'b0, 4'b0, 8'b0, 1'b0, "cold_pre");
                expect_at(3, 4'b0001, 4'b0, 8'b0000_0001, 1'b1, "cold_entry");
            end
            idle(1);
        end
        idle(3);

        // hysteresis on FRIO exit
        drive(4'b0001, 160, 0, 0, 0);
        expect_at(3, 4'b0001, 4'b0, 8'b0000_0001, 1'b1, "hyst_160");
        idle(3);
        drive(4'b0001, 170, 0, 0, 0);
        expect_at(2, 4'b0001, 4'b0, 8'b0000_0001, 1'b1, "hyst_hold");
        expect_at(3, 4'b0, 4'b0, 8'b0, 1'b0, "hyst_exit");
        idle(3);

        // limit values are in range
        for (int k = 0; k < 4; k++) drive(4'b0001, (k < 2) ? 150 : 350, 0, 0, 0);
        expect_at(3, 4'b0, 4'b0, 8'b0, 1'b0, "limits_ok");
        idle(3);

        // broken run on channel 2, then resume
        drive(4'b0100, 0, 0, 400, 0);
        drive(4'b0100, 0, 0, 400, 0);
        drive(4'b0100, 0, 0, 400, 0);
        drive(4'b0100, 0, 0, 300, 0);
        drive(4'b0100, 0, 0, 400, 0);
        expect_at(3, 4'b0, 4'b0, 8'b0, 1'b0, "run_broken");
        drive(4'b0100, 0, 0, 400, 0);
        drive(4'b0100, 0, 0, 400, 0);
        expect_at(3, 4'b0, 4'b0, 8'b0, 1'b0, "run_three");
        drive(4'b0100, 0, 0, 400, 0);
        expect_at(2, 4'b0, 4'b0, 8'b0, 1'b0, "run_pre");
        expect_at(3, 4'b0, 4'b0100, 8'b0010_0000, 1'b1, "run_calor");
        idle(3);

        // channel 1 into CALOR
        for (int k = 0; k < 4; k++) drive(4'b0010, 0, 400, 0, 0);
        expect_at(3, 4'b0, 4'b0110, 8'b0010_1000, 1'b1, "ch1_calor");
        idle(3);

        // direct CALOR->FRIO on ch1 while ch3 enters CALOR
        for (int k = 0; k < 4; k++) begin
            drive(4'b1010, 0, -50, 0, 400);
            if (k < 3)
                expect_at(3, 4'b0, 4'b0110, 8'b0010_1000, 1'b1, "swap_hold");
            else
                expect_at(3, 4'b0010, 4'b1100, 8'b1010_0100, 1'b1, "swap_done");
        end
        idle(3);

        // CALOR hysteresis band holds
        drive(4'b0100, 0, 0, 340, 0);
        expect_at(3, 4'b0010, 4'b1100, 8'b1010_0100, 1'b1, "calor_hyst_340");
        idle(3);

        // clear while faulted has no effect
        @(negedge clk);
        alerta_clr = 1'b1;
        expect_at(1, 4'b0010, 4'b1100, 8'b1010_0100, 1'b1, "clr_faulted");
        @(negedge clk);
        alerta_clr = 1'b0;
        expect_at(1, 4'b0010, 4'b1100, 8'b1010_0100, 1'b1, "clr_faulted2");

        // recovery of all channels
        drive(4'b1110, 0, 200, 200, 200);
        expect_at(3, 4'b0, 4'b0, 8'b0, STICKY, "recover");
        idle(3);

        // clear with every channel NORMAL
        @(negedge clk);
        alerta_clr = 1'b1;
        expect_at(1, 4'b0, 4'b0, 8'b0, 1'b0, "clr_normal");
        @(negedge clk);
        alerta_clr = 1'b0;
        idle(5);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/monitoreo_multicanal.md
Name: monitoreo_multicanal

Overview:
Parametrised multi-channel successor to the single-channel temperature monitor. Each of N_CANALES channels independently:
- registers a validated sensor sample
- classifies it against low/high limits with hysteresis on exit
- confirms an out-of-range condition only after PERSIST consecutive valid samples
- drives its own heater/fan pair

Sits between the sensor sampling front-end and the actuator drivers, and provides a global alert.

Parameters:
N_CANALES, 4, number of independent channels (1..16)
ANCHO, 11, signed temperature width in bits (two's complement)
LIM_BAJO, 150, signed low limit; sample < LIM_BAJO is cold
LIM_ALTO, 350, signed high limit; sample > LIM_ALTO is hot; must satisfy LIM_BAJO + 2*HIST < LIM_ALTO
HIST, 20, hysteresis margin (>= 0) applied when leaving a fault state
PERSIST, 4, consecutive same-direction out-of-range valid samples needed to enter a fault state (>= 1)

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  reset, synchronous, active-high
temp_entrada  input  N_CANALES*ANCHO  packed signed samples; channel i at bits [i*ANCHO +: ANCHO]
temp_valida  input  N_CANALES  per-channel sample strobe; sample is captured when the bit is 1 at a rising edge
alerta_clr  input  1  alert clear pulse; used only when MONITOREO_ALERTA_RETENIDA_EN is defined, ignored otherwise
calefactor  output  N_CANALES  heater on; 1 iff channel state is FRIO
ventilador  output  N_CANALES  fan on; 1 iff channel state is CALOR
estado_actual  output  2*N_CANALES  per-channel state code: 00 NORMAL, 01 FRIO, 10 CALOR; 11 never driven
alerta  output  1  global alert

Behaviour:
- Reset is synchronous: rst high at a rising edge clears every register on that edge, including mid-operation. After reset:
  - all channels are NORMAL
  - counters = 0
  - pending flags = 0
  - calefactor = 0, ventilador = 0, estado_actual = 0, alerta = 0
- Stage 1 (capture):
  - temp_valida[i] = 1 at edge E latches the sample into temp_reg[i] and sets pend[i].
  - Otherwise pend[i] clears.
  - Channels are fully independent; any mix of simultaneous strobes is legal.
- Stage 2 (classify/update), at edge E+1 when pend[i] = 1:
  - Classify the sample: FRIO_C if temp_reg < LIM_BAJO; CALOR_C if temp_reg > LIM_ALTO; else OK_C.
  - Compare signed. Compute LIM_BAJO+HIST and LIM_ALTO-HIST in ANCHO+1 bits so they cannot overflow.
- Persistence counter:
  - Width $clog2(PERSIST+1).
  - Holds the count of consecutive same-class out-of-range valid samples and saturates at PERSIST.
  - An OK_C sample clears it.
  - A class change between FRIO_C and CALOR_C reloads it to 1.
  - Cycles with no valid sample leave the counter untouched; gaps do not break the run.
- Channel FSM, evaluated only when pend[i] = 1:
  - NORMAL -> FRIO when the updated count reaches PERSIST with class FRIO_C.
  - NORMAL -> CALOR when the updated count reaches PERSIST with class CALOR_C.
  - FRIO -> NORMAL when LIM_BAJO+HIST <= sample <= LIM_ALTO. Samples in [LIM_BAJO, LIM_BAJO+HIST) keep FRIO and clear the counter.
  - FRIO -> CALOR directly when a CALOR_C run reaches PERSIST.
  - CALOR is symmetric: exit to NORMAL when LIM_BAJO <= sample <= LIM_ALTO-HIST; direct CALOR -> FRIO on a PERSIST-long FRIO_C run.
  - The counter clears on every state transition.
- Outputs:
  - All outputs are registered and decoded from the state register.
  - Latency from the PERSIST-th qualifying sample at the temp_valida edge to calefactor/ventilador change: 2 clock edges.
  - Release latency is also 2 edges.
- alerta (default): registered OR over all channels of (state != NORMAL), one edge after the state register changes.
- PERSIST = 1: a single out-of-range sample enters the fault state.

Optional Feature:
Macro MONITOREO_ALERTA_RETENIDA_EN.
- Defined: alerta is sticky. It sets whenever any channel is not NORMAL and stays 1 after all channels return to NORMAL. It clears only on an alerta_clr pulse while every channel is NORMAL. If alerta_clr coincides with a channel being or becoming non-NORMAL, set wins and alerta stays 1.
- Undefined: alerta follows the non-sticky OR described above; alerta_clr has no effect.

Decomposition:
- Package monitoreo_pkg holds:
  - typedef enum logic [1:0] estado_e {NORMAL=2'b00, FRIO=2'b01, CALOR=2'b10}
  - typedef enum clase_e {OK_C, FRIO_C, CALOR_C}
  - a function that classifies a signed sample
- Sub-module canal_temp holds one channel's capture register, pending flag, counter and FSM. It is instantiated N_CANALES times in a generate loop.
- The top level adds only slicing, output concatenation and alerta logic.

Test Plan:
All scenarios use the default parameters.
1. Reset: drive rst = 1 for 2 cycles with temp_valida = all-ones and samples of 500 -> all outputs remain 0; after release, the FSM state reflects only samples taken post-reset.
2. Cold entry: channel 0 gets 4 valid samples of 100 with 1-cycle gaps between them -> calefactor[0] = 1 exactly 2 edges after the 4th strobe; estado_actual[1:0] = 01; alerta = 1; other channels unaffected.
3. Hysteresis: from FRIO, a sample of 160 keeps FRIO; a sample of 170 returns to NORMAL, with calefactor[0] = 0 two edges later.
4. Run broken: samples 400, 400, 400, 300, 400 on channel 2 -> stays NORMAL with counter = 1. Then 400, 400, 400 -> CALOR, ventilador[2] = 1.
5. Direct swap and concurrency: channel 1 in CALOR receives 4 samples of -50 (signed) while channel 3 simultaneously enters CALOR -> channel 1 goes CALOR -> FRIO with no NORMAL cycle; outputs stay independent.
6. With MONITOREO_ALERTA_RETENIDA_EN defined: a fault then recovery leaves alerta = 1. An alerta_clr pulse while any channel is faulted leaves alerta = 1. An alerta_clr pulse with all channels NORMAL gives alerta = 0 on the next edge.
